// File: rtl/r5p_bus_pkg.sv
// Shared types and constants for the two-requester (program/data) bus arbiter.
package r5p_bus_pkg;

  // Arbiter FSM states: IDLE decides a grant combinationally, LOCK_x holds x
  // until its transfer completes or x abandons the request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_P = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  // Requester indices; also the bit positions inside the one-hot grant {D,P}.
  localparam int ARB_P = 0;
  localparam int ARB_D = 1;

endpackage

// File: rtl/r5p_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// "last" is the index of the requester that completed most recently.
// Under contention the other requester wins.
module r5p_rr_arb2
  import r5p_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Single requester always wins; on contention the one not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == 1'(ARB_D)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/r5p_bus_arb.sv
// Program/data bus arbiter onto one shared memory port.
//
// Handshake: a transfer completes in any cycle where mem_req and mem_ack are
// both high; the memory may ack in the request cycle or any later cycle. The
// requester keeps req and its request fields stable until it sees its ack, or
// drops req to abandon the transfer. Acks are routed only to the grantee.
//
// Grant is a function of state, "last" and the two req inputs only, so there
// is no combinational path from mem_ack to gnt or mem_req.
module r5p_bus_arb
  import r5p_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW/8
) (
  input  logic            clk,
  input  logic            rst,
  // program (fetch) requester, read-only
  input  logic            bup_req,
  input  logic [AW-1:0]   bup_adr,
  output logic [SW*8-1:0] bup_rdt,
  output logic            bup_ack,
  // data requester
  input  logic            bud_req,
  input  logic            bud_wen,
  input  logic [AW-1:0]   bud_adr,
  input  logic [SW-1:0]   bud_sel,
  input  logic [SW*8-1:0] bud_wdt,
  output logic [SW*8-1:0] bud_rdt,
  output logic            bud_ack,
  // shared memory port
  output logic            mem_req,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_adr,
  output logic [SW-1:0]   mem_sel,
  output logic [SW*8-1:0] mem_wdt,
  input  logic [SW*8-1:0] mem_rdt,
  input  logic            mem_ack,
  // current grant, one-hot {D,P}
  output logic [1:0]      gnt,
  // FSM state, exposed for observation
  output arb_state_t      state
);

  arb_state_t state_nxt;
  logic       last;
  logic       last_nxt;
  logic [1:0] rr_gnt;

  r5p_rr_arb2 u_rr (
    .req  ({bud_req, bup_req}),
    .last (last),
    .gnt  (rr_gnt)
  );

  // Grant: round-robin in IDLE, held on the owner while locked; an owner that
  // drops req loses the grant in that same cycle (abort). Reset masks all.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state)
        IDLE:    gnt = rr_gnt;
        LOCK_P:  gnt = bup_req ? 2'b01 : 2'b00;
        LOCK_D:  gnt = bud_req ? 2'b10 : 2'b00;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Memory request mux; program side is read-only with all byte lanes enabled.
  always_comb begin
    mem_req = 1'b0;
    mem_wen = 1'b0;
    mem_adr = bup_adr;
    mem_sel = '1;
    mem_wdt = bud_wdt;
    if (gnt[ARB_D]) begin
      mem_req = 1'b1;
      mem_wen = bud_wen;
      mem_adr = bud_adr;
      mem_sel = bud_sel;
    end else if (gnt[ARB_P]) begin
      mem_req = 1'b1;
    end
  end

  // Response routing: read data broadcast, ack only to the grantee.
  always_comb begin
    bup_rdt = mem_rdt;
    bud_rdt = mem_rdt;
    bup_ack = gnt[ARB_P] & mem_ack;
    bud_ack = gnt[ARB_D] & mem_ack;
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          if (mem_ack) last_nxt  = gnt[ARB_D];
          else         state_nxt = gnt[ARB_D] ? LOCK_D : LOCK_P;
        end
      end
      LOCK_P: begin
        if (!bup_req) begin
          state_nxt = IDLE;
        end else if (mem_ack) begin
          state_nxt = IDLE;
          last_nxt  = 1'(ARB_P);
        end
      end
      LOCK_D: begin
        if (!bud_req) begin
          state_nxt = IDLE;
        end else if (mem_ack) begin
          state_nxt = IDLE;
          last_nxt  = 1'(ARB_D);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset marks P as last so D wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'(ARB_P);
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Directed bench for r5p_bus_arb plus a constrained random traffic phase.
module tb_r5p_bus_arb;
  import r5p_bus_pkg::*;

  localparam int AW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            bup_req;
  logic [AW-1:0]   bup_adr;
  logic [SW*8-1:0] bup_rdt;
  logic            bup_ack;
  logic            bud_req;
  logic            bud_wen;
  logic [AW-1:0]   bud_adr;
  logic [SW-1:0]   bud_sel;
  logic [SW*8-1:0] bud_wdt;
  logic [SW*8-1:0] bud_rdt;
  logic            bud_ack;
  logic            mem_req;
  logic            mem_wen;
  logic [AW-1:0]   mem_adr;
  logic [SW-1:0]   mem_sel;
  logic [SW*8-1:0] mem_wdt;
  logic [SW*8-1:0] mem_rdt;
  logic            mem_ack;
  logic [1:0]      gnt;
  arb_state_t      state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  r5p_bus_arb #(.AW(AW), .DW(32), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .bup_req(bup_req), .bup_adr(bup_adr), .bup_rdt(bup_rdt), .bup_ack(bup_ack),
    .bud_req(bud_req), .bud_wen(bud_wen), .bud_adr(bud_adr), .bud_sel(bud_sel),
    .bud_wdt(bud_wdt), .bud_rdt(bud_rdt), .bud_ack(bud_ack),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_adr(mem_adr), .mem_sel(mem_sel),
    .mem_wdt(mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack),
    .gnt(gnt), .state(state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // grant, both acks and mem_req in one go
  task automatic chk_bus(input string tag, input logic [1:0] e_gnt, input logic e_pack,
                         input logic e_dack, input logic e_mreq);
    check({tag, ".gnt"},  gnt,     e_gnt);
    check({tag, ".pack"}, bup_ack, e_pack);
    check({tag, ".dack"}, bud_ack, e_dack);
    check({tag, ".mreq"}, mem_req, e_mreq);
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p(input logic req, input logic [AW-1:0] adr);
    bup_req = req;
    bup_adr = adr;
  endtask

  task automatic drive_d(input logic req, input logic wen, input logic [AW-1:0] adr,
                         input logic [SW-1:0] sel, input logic [SW*8-1:0] wdt);
    bud_req = req;
    bud_wen = wen;
    bud_adr = adr;
    bud_sel = sel;
    bud_wdt = wdt;
  endtask

  logic            p_acked, d_acked, prev_valid;
  logic [AW-1:0]   prev_adr;
  logic            prev_wen;
  logic [SW-1:0]   prev_sel;

  initial begin
    rst = 1'b1;
    drive_p(1'b1, 32'h0);
    drive_d(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_ack = 1'b1;
    mem_rdt = 32'hCAFE_0001;

    // reset: everything quiet regardless of requests and ack
    next_cycle();
    @(negedge clk);
    chk_bus("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    check("rst.state", state, IDLE);
    next_cycle();
    rst = 1'b0;

    // zero-wait contention alternates D, P, D, P
    @(negedge clk); chk_bus("alt1", 2'b10, 1'b0, 1'b1, 1'b1);
    check("alt1.rdt", bud_rdt, 32'hCAFE_0001);
    next_cycle();
    @(negedge clk); chk_bus("alt2", 2'b01, 1'b1, 1'b0, 1'b1);
    check("alt2.rdt", bup_rdt, 32'hCAFE_0001);
    next_cycle();
    @(negedge clk); chk_bus("alt3", 2'b10, 1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk); chk_bus("alt4", 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle();

    // P alone at 0x100, ack after 3 wait cycles
    drive_p(1'b1, 32'h100);
    drive_d(1'b0, 1'b1, 32'h5555, 4'h1, 32'h0);
    mem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_ack = 1'b1;
      @(negedge clk);
      check("p3w.adr", mem_adr, 32'h100);
      check("p3w.wen", mem_wen, 1'b0);
      check("p3w.sel", mem_sel, 4'hF);
      chk_bus("p3w", 2'b01, (c == 4), 1'b0, 1'b1);
      if (c > 1) check("p3w.state", state, LOCK_P);
      next_cycle();
    end
    check("p3w.idle", state, IDLE);

    // D arrives while P is locked; D must wait until after P's ack
    drive_p(1'b1, 32'h200);
    mem_ack = 1'b0;
    @(negedge clk); chk_bus("lkp0", 2'b01, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive_d(1'b1, 1'b1, 32'h2000, 4'h3, 32'h1234_5678);
    @(negedge clk); chk_bus("lkp1", 2'b01, 1'b0, 1'b0, 1'b1);
    check("lkp1.adr", mem_adr, 32'h200);
    check("lkp1.wen", mem_wen, 1'b0);
    next_cycle();
    mem_ack = 1'b1;
    @(negedge clk); chk_bus("lkp2", 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk); chk_bus("dwin", 2'b10, 1'b0, 1'b0, 1'b1);
    check("dwin.wen", mem_wen, 1'b1);
    check("dwin.adr", mem_adr, 32'h2000);
    check("dwin.sel", mem_sel, 4'h3);
    check("dwin.wdt", mem_wdt, 32'h1234_5678);
    next_cycle();
    // finish the D write alone, so last becomes D
    drive_p(1'b0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk); chk_bus("dfin", 2'b10, 1'b0, 1'b1, 1'b1);
    check("dfin.state", state, LOCK_D);
    next_cycle();

    // D locks again then aborts; pointer stays D so contention grants P
    mem_ack = 1'b0;
    drive_d(1'b1, 1'b0, 32'h3000, 4'hF, 32'h0);
    @(negedge clk); chk_bus("ab0", 2'b10, 1'b0, 1'b0, 1'b1);
    next_cycle();
    bud_req = 1'b0;
    bup_req = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk); chk_bus("ab1", 2'b00, 1'b0, 1'b0, 1'b0);
    check("ab1.state", state, LOCK_D);
    next_cycle();
    bud_req = 1'b1;
    @(negedge clk); chk_bus("ab2", 2'b01, 1'b1, 1'b0, 1'b1);
    check("ab2.state", state, IDLE);
    next_cycle();

    // D completes alone (last=D), locks, then reset mid-transfer
    bup_req = 1'b0;
    @(negedge clk); chk_bus("rs0", 2'b10, 1'b0, 1'b1, 1'b1);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk); chk_bus("rs1", 2'b10, 1'b0, 1'b0, 1'b1);
    next_cycle();
    rst = 1'b1;
    bup_req = 1'b1;
    @(negedge clk); chk_bus("rs2", 2'b00, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk); chk_bus("rs3", 2'b10, 1'b0, 1'b0, 1'b1);
    check("rs3.state", state, IDLE);
    next_cycle();
    mem_ack = 1'b1;
    @(negedge clk); chk_bus("rs4", 2'b10, 1'b0, 1'b1, 1'b1);
    next_cycle();

    // random traffic; requesters hold fields until acked or aborted
    p_acked = 1'b0;
    d_acked = 1'b0;
    prev_valid = 1'b0;
    prev_adr = '0;
    prev_wen = 1'b0;
    prev_sel = '0;
    drive_p(1'b0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      if (!bup_req || p_acked) begin
        bup_req = 1'($urandom_range(0, 1));
        bup_adr = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bup_req = 1'b0;
      end
      if (!bud_req || d_acked) begin
        drive_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)), $urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        bud_req = 1'b0;
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdt = $urandom;
      @(negedge clk);
      check("r.ack_excl", 64'(bup_ack & bud_ack), 64'd0);
      check("r.gnt_1h0", 64'($onehot0(gnt)), 64'd1);
      check("r.mreq", mem_req, 64'(bup_req | bud_req) & 64'(gnt != 2'b00));
      check("r.rdt", {bup_rdt, bud_rdt}, {mem_rdt, mem_rdt});
      if (prev_valid && gnt != 2'b00) begin
        check("r.lock_state", 64'(state != IDLE), 64'd1);
        check("r.stable_adr", mem_adr, prev_adr);
        check("r.stable_wen", mem_wen, prev_wen);
        check("r.stable_sel", mem_sel, prev_sel);
      end
      prev_valid = (gnt != 2'b00) && !mem_ack;
      prev_adr = mem_adr;
      prev_wen = mem_wen;
      prev_sel = mem_sel;
      p_acked = bup_ack;
      d_acked = bud_ack;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
